ysyx_041461_axi_arbiter: RTL and testbench



---
 rtl/ysyx_041461_axi_pkg.sv | 32 +++
 rtl/ysyx_041461_rr_arb2.sv | 42 ++++
 rtl/ysyx_041461_axi_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_ysyx_041461_axi_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041461_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_041461_axi_pkg
// Description : Shared AXI widths, response encodings and arbiter FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_041461_axi_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_041461_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_041461_rr_arb2
// Description : Two-input round-robin grant; tie goes to the input not last granted.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_041461_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        last_d = last_q;
        if (en_i && (|req_i)) begin
            last_d = gnt_o[1];
        end
    end

    // Reset value 1 makes input 0 win the very first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_041461_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_041461_axi_arbiter
// Description : IFU/LSU to single-slave AXI4 arbiter, one outstanding read and write.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_041461_axi_arbiter
    import ysyx_041461_axi_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    // master 0 (IFU) read
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [ID_W-1:0]     m0_rid,
    output logic [1:0]          m0_rresp,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rlast,
    // master 1 (LSU) read
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [ID_W-1:0]     m1_rid,
    output logic [1:0]          m1_rresp,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rlast,
    // master 1 (LSU) write
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ID_W-1:0]     m1_bid,
    output logic [1:0]          m1_bresp,
    // slave read
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ID_W-1:0]     s_arid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [ID_W-1:0]     s_rid,
    input  logic [1:0]          s_rresp,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rlast,
    // slave write
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ID_W-1:0]     s_awid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [ID_W-1:0]     s_bid,
    input  logic [1:0]          s_bresp
);

    rd_state_e  rd_state_q;
    wr_state_e  wr_state_q;
    logic       rd_owner_q;
    logic [1:0] ar_gnt;

    ysyx_041461_rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .req_i ({m1_arvalid, m0_arvalid}),
        .en_i  (rd_state_q == R_IDLE),
        .gnt_o (ar_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_owner_q <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        rd_owner_q <= ar_gnt[1];
                        rd_state_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (s_arvalid && s_arready) begin
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_rvalid && s_rready && s_rlast) begin
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
        end else begin
            case (wr_state_q)
                W_IDLE: if (m1_awvalid)                        wr_state_q <= W_ADDR;
                W_ADDR: if (s_awvalid && s_awready)            wr_state_q <= W_DATA;
                W_DATA: if (s_wvalid && s_wready && s_wlast)   wr_state_q <= W_RESP;
                W_RESP: if (s_bvalid && s_bready)              wr_state_q <= W_IDLE;
                default:                                       wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Read channel routing: everything not owned by the current state is held at zero.
    always_comb begin
        s_arvalid  = 1'b0;
        s_arid     = '0;
        s_araddr   = '0;
        s_arlen    = '0;
        s_arsize   = '0;
        s_arburst  = '0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_rready   = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rid     = '0;
        m0_rresp   = '0;
        m0_rdata   = '0;
        m0_rlast   = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rid     = '0;
        m1_rresp   = '0;
        m1_rdata   = '0;
        m1_rlast   = 1'b0;
        if (rd_state_q == R_ADDR) begin
            if (rd_owner_q) begin
                s_arvalid  = m1_arvalid;
                s_arid     = m1_arid;
                s_araddr   = m1_araddr;
                s_arlen    = m1_arlen;
                s_arsize   = m1_arsize;
                s_arburst  = m1_arburst;
                m1_arready = s_arready;
            end else begin
                s_arvalid  = m0_arvalid;
                s_arid     = m0_arid;
                s_araddr   = m0_araddr;
                s_arlen    = m0_arlen;
                s_arsize   = m0_arsize;
                s_arburst  = m0_arburst;
                m0_arready = s_arready;
            end
        end
        if (rd_state_q == R_DATA) begin
            if (rd_owner_q) begin
                m1_rvalid = s_rvalid;
                m1_rid    = s_rid;
                m1_rresp  = s_rresp;
                m1_rdata  = s_rdata;
                m1_rlast  = s_rlast;
                s_rready  = m1_rready;
            end else begin
                m0_rvalid = s_rvalid;
                m0_rid    = s_rid;
                m0_rresp  = s_rresp;
                m0_rdata  = s_rdata;
                m0_rlast  = s_rlast;
                s_rready  = m0_rready;
            end
        end
    end

    always_comb begin
        s_awvalid  = 1'b0;
        s_awid     = '0;
        s_awaddr   = '0;
        s_awlen    = '0;
        s_awsize   = '0;
        s_awburst  = '0;
        m1_awready = 1'b0;
        s_wvalid   = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wlast    = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bid     = '0;
        m1_bresp   = '0;
        s_bready   = 1'b0;
        case (wr_state_q)
            W_ADDR: begin
                s_awvalid  = m1_awvalid;
                s_awid     = m1_awid;
                s_awaddr   = m1_awaddr;
                s_awlen    = m1_awlen;
                s_awsize   = m1_awsize;
                s_awburst  = m1_awburst;
                m1_awready = s_awready;
            end
            W_DATA: begin
                s_wvalid  = m1_wvalid;
                s_wdata   = m1_wdata;
                s_wstrb   = m1_wstrb;
                s_wlast   = m1_wlast;
                m1_wready = s_wready;
            end
            W_RESP: begin
                m1_bvalid = s_bvalid;
                m1_bid    = s_bid;
                m1_bresp  = s_bresp;
                s_bready  = m1_bready;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_041461_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_041461_axi_arbiter
// Description : Directed self-checking bench for the two-master AXI arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_041461_axi_arbiter;
    import ysyx_041461_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [3:0]  m0_arid, m0_rid;
    logic [31:0] m0_araddr;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic [63:0] m0_rdata;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [3:0]  m1_arid, m1_rid;
    logic [31:0] m1_araddr;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst, m1_rresp;
    logic [63:0] m1_rdata;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
    logic [3:0]  m1_awid, m1_bid;
    logic [31:0] m1_awaddr;
    logic [7:0]  m1_awlen;
    logic [2:0]  m1_awsize;
    logic [1:0]  m1_awburst, m1_bresp;
    logic [63:0] m1_wdata;
    logic [7:0]  m1_wstrb;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [3:0]  s_arid, s_rid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic [63:0] s_rdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [3:0]  s_awid, s_bid;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;

    int errors = 0;
    int checks = 0;

    ysyx_041461_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid), .m0_araddr(m0_araddr),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid), .m0_rresp(m0_rresp),
        .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid), .m1_araddr(m1_araddr),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid), .m1_rresp(m1_rresp),
        .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awid(m1_awid), .m1_awaddr(m1_awaddr),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bid(m1_bid),
        .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rresp(s_rresp),
        .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
        .s_bresp(s_bresp)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        m0_arvalid = 0; m0_arid = 0; m0_araddr = 0; m0_arlen = 0; m0_arsize = 0; m0_arburst = 0;
        m0_rready = 0;
        m1_arvalid = 0; m1_arid = 0; m1_araddr = 0; m1_arlen = 0; m1_arsize = 0; m1_arburst = 0;
        m1_rready = 0;
        m1_awvalid = 0; m1_awid = 0; m1_awaddr = 0; m1_awlen = 0; m1_awsize = 0; m1_awburst = 0;
        m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wlast = 0; m1_bready = 0;
        s_arready = 0; s_rvalid = 0; s_rid = 0; s_rresp = 0; s_rdata = 0; s_rlast = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bid = 0; s_bresp = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1; clear_inputs();
        @(negedge clk); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        m0_arvalid = 1; m0_araddr = 32'h1234_5678; m1_awvalid = 1; m1_wvalid = 1;
        s_rvalid = 1; s_bvalid = 1; s_rdata = 64'hFFFF;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL rst_s_arvalid got=%0h exp=0", s_arvalid); end
        checks++; if (s_araddr !== 32'h0) begin errors++; $display("FAIL rst_s_araddr got=%0h exp=0", s_araddr); end
        checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 64'h0) begin errors++; $display("FAIL rst_m0_r got=%0h/%0h exp=0/0", m0_rvalid, m0_rdata); end
        checks++; if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0) begin errors++; $display("FAIL rst_s_aw_w got=%0h/%0h exp=0/0", s_awvalid, s_wvalid); end
        checks++; if (m1_bvalid !== 1'b0 || s_rready !== 1'b0) begin errors++; $display("FAIL rst_b_rready got=%0h/%0h exp=0/0", m1_bvalid, s_rready); end
        @(negedge clk); rst = 0; clear_inputs();
    endtask

    task automatic test_single_read();
        @(negedge clk);
        m0_arvalid = 1; m0_arid = 4'h3; m0_araddr = 32'h8000_0000; m0_arlen = 0; m0_arsize = 3; m0_arburst = 1;
        #1;
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL sr_lat_idle got=%0h exp=0", s_arvalid); end
        @(negedge clk); s_arready = 1; #1;
        checks++; if (s_arvalid !== 1'b1) begin errors++; $display("FAIL sr_s_arvalid got=%0h exp=1", s_arvalid); end
        checks++; if (s_araddr !== 32'h8000_0000 || s_arid !== 4'h3) begin errors++; $display("FAIL sr_ar_payload got=%0h/%0h exp=80000000/3", s_araddr, s_arid); end
        checks++; if (s_arlen !== 8'h0 || s_arsize !== 3'd3 || s_arburst !== 2'd1) begin errors++; $display("FAIL sr_ar_ctl got=%0h/%0h/%0h exp=0/3/1", s_arlen, s_arsize, s_arburst); end
        checks++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin errors++; $display("FAIL sr_arready got=%0h/%0h exp=1/0", m0_arready, m1_arready); end
        @(negedge clk);
        m0_arvalid = 0; s_arready = 0;
        s_rvalid = 1; s_rid = 4'h3; s_rdata = 64'hDEAD_BEEF_0BAD_F00D; s_rresp = AXI_RESP_OKAY; s_rlast = 1; m0_rready = 1;
        #1;
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 64'hDEAD_BEEF_0BAD_F00D) begin errors++; $display("FAIL sr_m0_rdata got=%0h/%0h exp=1/deadbeef0badf00d", m0_rvalid, m0_rdata); end
        checks++; if (m0_rlast !== 1'b1 || m0_rid !== 4'h3) begin errors++; $display("FAIL sr_m0_rlast_rid got=%0h/%0h exp=1/3", m0_rlast, m0_rid); end
        checks++; if (m1_rvalid !== 1'b0 || s_rready !== 1'b1) begin errors++; $display("FAIL sr_m1_rvalid_s_rready got=%0h/%0h exp=0/1", m1_rvalid, s_rready); end
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL sr_ar_closed got=%0h exp=0", s_arvalid); end
        @(negedge clk); #1;
        checks++; if (m0_rvalid !== 1'b0 || s_rready !== 1'b0) begin errors++; $display("FAIL sr_back_idle got=%0h/%0h exp=0/0", m0_rvalid, s_rready); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        @(negedge clk);
        m0_arvalid = 1; m0_arid = 4'h1; m0_araddr = 32'h8000_0100;
        m1_arvalid = 1; m1_arid = 4'h2; m1_araddr = 32'h8000_0200;
        @(negedge clk); s_arready = 1; #1;
        checks++; if (s_araddr !== 32'h8000_0100 || m0_arready !== 1'b1 || m1_arready !== 1'b0) begin errors++; $display("FAIL rr_first_m0 got=%0h/%0h/%0h exp=80000100/1/0", s_araddr, m0_arready, m1_arready); end
        @(negedge clk);
        m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 64'hA0; m0_rready = 1; m1_rready = 1;
        #1;
        checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL rr_first_r got=%0h/%0h exp=1/0", m0_rvalid, m1_rvalid); end
        @(negedge clk); s_rvalid = 0; #1;
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL rr_idle_gap got=%0h exp=0", s_arvalid); end
        @(negedge clk); s_arready = 1; #1;
        checks++; if (s_araddr !== 32'h8000_0200 || s_arid !== 4'h2 || m1_arready !== 1'b1 || m0_arready !== 1'b0) begin errors++; $display("FAIL rr_second_m1 got=%0h/%0h/%0h/%0h exp=80000200/2/1/0", s_araddr, s_arid, m1_arready, m0_arready); end
        @(negedge clk);
        m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 64'hA1;
        #1;
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 64'hA1 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL rr_second_r got=%0h/%0h/%0h exp=1/a1/0", m1_rvalid, m1_rdata, m0_rvalid); end
        @(negedge clk); s_rvalid = 0; m0_arvalid = 1; m1_arvalid = 1;
        @(negedge clk); s_arready = 1; #1;
        checks++; if (s_araddr !== 32'h8000_0100 || m0_arready !== 1'b1) begin errors++; $display("FAIL rr_third_m0 got=%0h/%0h exp=80000100/1", s_araddr, m0_arready); end
        @(negedge clk);
        m0_arvalid = 0; m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1;
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_burst();
        logic [63:0] got [4];
        logic        lastf [4];
        int          nbeats;
        int          beat;
        @(negedge clk);
        m1_arvalid = 1; m1_arid = 4'h6; m1_araddr = 32'h8000_2000; m1_arlen = 8'd3; m1_arsize = 3; m1_arburst = 1;
        @(negedge clk); s_arready = 1; #1;
        checks++; if (m1_arready !== 1'b1 || s_arlen !== 8'd3) begin errors++; $display("FAIL burst_ar got=%0h/%0h exp=1/3", m1_arready, s_arlen); end
        @(negedge clk); m1_arvalid = 0; s_arready = 0;
        nbeats = 0; beat = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            m1_rready = (i % 2 == 0);
            s_rvalid = 1; s_rid = 4'h6; s_rdata = 64'hB000 + 64'(beat); s_rlast = (beat == 3);
            #1;
            if (m1_rvalid && m1_rready && nbeats < 4) begin
                got[nbeats] = m1_rdata; lastf[nbeats] = m1_rlast; nbeats++;
            end
            if (s_rvalid && s_rready) beat++;
        end
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL burst_after_last got=%0h exp=0", m1_rvalid); end
        checks++; if (nbeats != 4) begin errors++; $display("FAIL burst_count got=%0d exp=4", nbeats); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (k < nbeats && (got[k] !== 64'hB000 + 64'(k) || lastf[k] !== (k == 3))) begin errors++; $display("FAIL burst_beat%0d got=%0h/%0h exp=%0h/%0h", k, got[k], lastf[k], 64'hB000 + 64'(k), (k == 3)); end
        end
        clear_inputs();
    endtask

    task automatic test_write();
        @(negedge clk);
        m1_awvalid = 1; m1_awid = 4'h5; m1_awaddr = 32'h8000_1000; m1_awlen = 0; m1_awsize = 3; m1_awburst = 1;
        m1_wvalid = 1; m1_wdata = 64'h1122_3344_5566_7788; m1_wstrb = 8'hFF; m1_wlast = 1;
        #1;
        checks++; if (s_awvalid !== 1'b0 || m1_wready !== 1'b0) begin errors++; $display("FAIL wr_idle got=%0h/%0h exp=0/0", s_awvalid, m1_wready); end
        @(negedge clk); s_awready = 1; #1;
        checks++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'h8000_1000 || s_awid !== 4'h5) begin errors++; $display("FAIL wr_aw got=%0h/%0h/%0h exp=1/80001000/5", s_awvalid, s_awaddr, s_awid); end
        checks++; if (m1_awready !== 1'b1 || s_wvalid !== 1'b0) begin errors++; $display("FAIL wr_awready got=%0h/%0h exp=1/0", m1_awready, s_wvalid); end
        @(negedge clk); m1_awvalid = 0; s_awready = 0; s_wready = 1; #1;
        checks++; if (s_awvalid !== 1'b0 || s_wvalid !== 1'b1) begin errors++; $display("FAIL wr_w_valid got=%0h/%0h exp=0/1", s_awvalid, s_wvalid); end
        checks++; if (s_wdata !== 64'h1122_3344_5566_7788 || s_wstrb !== 8'hFF || s_wlast !== 1'b1) begin errors++; $display("FAIL wr_w_payload got=%0h/%0h/%0h exp=1122334455667788/ff/1", s_wdata, s_wstrb, s_wlast); end
        checks++; if (m1_wready !== 1'b1) begin errors++; $display("FAIL wr_wready got=%0h exp=1", m1_wready); end
        @(negedge clk);
        m1_wvalid = 0; s_wready = 0; s_bvalid = 1; s_bid = 4'h5; s_bresp = AXI_RESP_OKAY; m1_bready = 1;
        #1;
        checks++; if (m1_bvalid !== 1'b1 || m1_bid !== 4'h5 || m1_bresp !== AXI_RESP_OKAY) begin errors++; $display("FAIL wr_b got=%0h/%0h/%0h exp=1/5/0", m1_bvalid, m1_bid, m1_bresp); end
        checks++; if (s_bready !== 1'b1 || s_wvalid !== 1'b0) begin errors++; $display("FAIL wr_bready got=%0h/%0h exp=1/0", s_bready, s_wvalid); end
        @(negedge clk); #1;
        checks++; if (m1_bvalid !== 1'b0 || s_bready !== 1'b0) begin errors++; $display("FAIL wr_back_idle got=%0h/%0h exp=0/0", m1_bvalid, s_bready); end
        clear_inputs();
    endtask

    task automatic test_concurrent();
        @(negedge clk);
        m0_arvalid = 1; m0_arid = 4'h7; m0_araddr = 32'h8000_3000;
        m1_awvalid = 1; m1_awid = 4'h9; m1_awaddr = 32'h8000_4000;
        m1_wvalid = 1; m1_wdata = 64'hCAFE; m1_wstrb = 8'h0F; m1_wlast = 1;
        @(negedge clk); s_arready = 1; s_awready = 1; #1;
        checks++; if (s_arvalid !== 1'b1 || s_awvalid !== 1'b1) begin errors++; $display("FAIL cc_addr got=%0h/%0h exp=1/1", s_arvalid, s_awvalid); end
        @(negedge clk);
        m0_arvalid = 0; m1_awvalid = 0; s_arready = 0; s_awready = 0;
        s_rvalid = 1; s_rlast = 1; s_rdata = 64'h5A5A; m0_rready = 1; s_wready = 1;
        #1;
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 64'h5A5A) begin errors++; $display("FAIL cc_read got=%0h/%0h exp=1/5a5a", m0_rvalid, m0_rdata); end
        checks++; if (s_wvalid !== 1'b1 || m1_wready !== 1'b1 || s_wstrb !== 8'h0F) begin errors++; $display("FAIL cc_write got=%0h/%0h/%0h exp=1/1/f", s_wvalid, m1_wready, s_wstrb); end
        @(negedge clk);
        s_rvalid = 0; m1_wvalid = 0; s_wready = 0; s_bvalid = 1; s_bid = 4'h9; s_bresp = AXI_RESP_SLVERR; m1_bready = 1;
        #1;
        checks++; if (m1_bvalid !== 1'b1 || m1_bresp !== AXI_RESP_SLVERR || m1_bid !== 4'h9) begin errors++; $display("FAIL cc_resp got=%0h/%0h/%0h exp=1/2/9", m1_bvalid, m1_bresp, m1_bid); end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk); m0_arvalid = 1; m0_arid = 4'h1; m0_araddr = 32'h8000_0100;
        @(negedge clk); s_arready = 1;
        @(negedge clk);
        m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 0; s_rdata = 64'h77; m0_rready = 1;
        #1;
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL rm_pre got=%0h exp=1", m0_rvalid); end
        @(negedge clk); rst = 1; #1;
        checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 64'h0 || s_rready !== 1'b0) begin errors++; $display("FAIL rm_outputs got=%0h/%0h/%0h exp=0/0/0", m0_rvalid, m0_rdata, s_rready); end
        @(negedge clk);
        rst = 0; s_rvalid = 0; m0_arvalid = 1; m1_arvalid = 1; m1_araddr = 32'h8000_0200; m1_arid = 4'h2;
        #1;
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL rm_idle got=%0h exp=0", s_arvalid); end
        @(negedge clk); #1;
        checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0100) begin errors++; $display("FAIL rm_tie_m0 got=%0h/%0h exp=1/80000100", s_arvalid, s_araddr); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst();
        test_write();
        test_concurrent();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
